// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a job, requests key expansion, then paces rounds 0..Nr
// on the key expander's ready strobe while driving the datapath round controls.
module aes_round_ctrl #(
   parameter int unsigned RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [3:0]    Nk,
   input  logic          key_ready,
   output logic          key_valid,
   output logic          busy,
   output logic          ld_state,
   output logic          state_en,
   output logic          first_rnd,
   output logic          last_rnd,
   output logic [RW-1:0] round,
   output logic [RW-1:0] rk_idx,
   output logic [3:0]    nr_out,
   output logic          enc_finish,
   output logic          dec_finish,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {StIdle, StKeyReq, StWait, StRound, StDone} stateE;

   stateE         stateQ, stateD;
   logic          modeQ;
   logic [3:0]    nrQ;
   logic [RW-1:0] roundQ;
   logic          encFinQ, decFinQ, errQ;

   logic nkLegal, accept, isLast;

   assign nkLegal = (Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8);
   assign accept  = (stateQ == StIdle) && start && nkLegal;
   assign isLast  = (roundQ == RW'(nrQ));

   always_ff @(posedge clk) begin
      if (!rst) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:   if (accept) stateD = StKeyReq;
         StKeyReq: stateD = StWait;
         StWait:   if (key_ready) stateD = StRound;
         StRound:  stateD = isLast ? StDone : StWait;
         StDone:   stateD = StIdle;
         default:  stateD = StIdle;
      endcase
   end

   // Job registers; finish flags are set on entry to DONE so they rise together with done.
   always_ff @(posedge clk) begin
      if (!rst) begin
         modeQ   <= 1'b0;
         nrQ     <= 4'd0;
         roundQ  <= '0;
         encFinQ <= 1'b0;
         decFinQ <= 1'b0;
         errQ    <= 1'b0;
      end else begin
         errQ <= (stateQ == StIdle) && start && !nkLegal;
         if (accept) begin
            modeQ   <= mode;
            nrQ     <= Nk + 4'd6;
            roundQ  <= '0;
            encFinQ <= 1'b0;
            decFinQ <= 1'b0;
         end
         if (stateQ == StRound) begin
            if (isLast) begin
               encFinQ <= !modeQ;
               decFinQ <= modeQ;
            end else begin
               roundQ <= roundQ + RW'(1);
            end
         end
      end
   end

   always_comb begin
      key_valid  = (stateQ == StKeyReq);
      busy       = (stateQ != StIdle);
      state_en   = (stateQ == StRound);
      first_rnd  = (stateQ == StRound) && (roundQ == '0);
      ld_state   = first_rnd;
      last_rnd   = (stateQ == StRound) && isLast;
      done       = (stateQ == StDone);
      round      = roundQ;
      rk_idx     = modeQ ? (RW'(nrQ) - roundQ) : roundQ;
      nr_out     = nrQ;
      enc_finish = encFinQ;
      dec_finish = decFinQ;
      err        = errQ;
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: directed and randomized jobs checked against a round timeline
// computed from the start cycle, Nr and the chosen key_ready stall per round.
module tb_aes_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       mode;
   logic [3:0] Nk;
   logic       key_ready;
   logic       key_valid, busy, ld_state, state_en, first_rnd, last_rnd;
   logic [3:0] round, rk_idx, nr_out;
   logic       enc_finish, dec_finish, done, err;

   int passCnt = 0;
   int totalCnt = 0;

   // Model of what the idle block should show between jobs.
   bit mEnc = 0, mDec = 0, mMode = 0;
   int mRound = 0, mNr = 0;

   aes_round_ctrl #(.RW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .Nk(Nk), .key_ready(key_ready),
      .key_valid(key_valid), .busy(busy), .ld_state(ld_state), .state_en(state_en),
      .first_rnd(first_rnd), .last_rnd(last_rnd), .round(round), .rk_idx(rk_idx),
      .nr_out(nr_out), .enc_finish(enc_finish), .dec_finish(dec_finish), .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic checkAll(input string tag, input bit kv, input bit bz, input bit se,
                           input bit fr, input bit lr, input bit dn, input bit er,
                           input bit ef, input bit df, input int rnd, input int rk,
                           input int nr);
      chk({tag, " key_valid"}, 32'(key_valid), 32'(kv));
      chk({tag, " busy"}, 32'(busy), 32'(bz));
      chk({tag, " state_en"}, 32'(state_en), 32'(se));
      chk({tag, " ld_state"}, 32'(ld_state), 32'(fr));
      chk({tag, " first_rnd"}, 32'(first_rnd), 32'(fr));
      chk({tag, " last_rnd"}, 32'(last_rnd), 32'(lr));
      chk({tag, " done"}, 32'(done), 32'(dn));
      chk({tag, " err"}, 32'(err), 32'(er));
      chk({tag, " enc_finish"}, 32'(enc_finish), 32'(ef));
      chk({tag, " dec_finish"}, 32'(dec_finish), 32'(df));
      chk({tag, " round"}, 32'(round), 32'(rnd));
      chk({tag, " rk_idx"}, 32'(rk_idx), 32'(rk));
      chk({tag, " nr_out"}, 32'(nr_out), 32'(nr));
   endtask

   task automatic checkIdle(input string tag, input bit er);
      checkAll(tag, 0, 0, 0, 0, 0, 0, er, mEnc, mDec, mRound,
               mMode ? mNr - mRound : mRound, mNr);
   endtask

   task automatic resetModel();
      mEnc = 0; mDec = 0; mMode = 0; mRound = 0; mNr = 0;
   endtask

   // stallKind: 0 none, 1 random 0..2 per round, 2 three cycles before round 4.
   // abortAt: cycle after start at which rst is pulled low (0 = never).
   task automatic runJob(input bit m, input logic [3:0] nk, input int stallKind,
                         input int abortAt, input bit noise);
      int nr, doneC, rnd, w;
      int s[15];
      int t[15];
      bit kr[256];
      string tag;
      nr = int'(nk) + 6;
      for (int k = 0; k <= nr; k++)
         s[k] = (stallKind == 1) ? int'($urandom_range(2, 0)) :
                ((stallKind == 2 && k == 4) ? 3 : 0);
      t[0] = 3 + s[0];
      for (int k = 1; k <= nr; k++) t[k] = t[k-1] + 2 + s[k];
      doneC = t[nr] + 1;
      for (int c = 0; c < 256; c++) kr[c] = 1'($urandom_range(1, 0));
      for (int k = 0; k <= nr; k++) begin
         w = (k == 0) ? 2 : t[k-1] + 1;
         for (int c = w; c < t[k] - 1; c++) kr[c] = 1'b0;
         kr[t[k] - 1] = 1'b1;
      end

      mode = m; Nk = nk; start = 1'b1; key_ready = kr[0];
      tick();
      for (int c = 1; c <= doneC; c++) begin
         rnd = 0;
         for (int k = 0; k <= nr; k++) if (t[k] < c) rnd++;
         if (rnd > nr) rnd = nr;
         tag = $sformatf("m%0d nk%0d c%0d", m, nk, c);
         begin
            bit isRound, isFirst, isLastR;
            isRound = 0;
            for (int k = 0; k <= nr; k++) if (t[k] == c) isRound = 1;
            isFirst = (c == t[0]);
            isLastR = (c == t[nr]);
            checkAll(tag, c == 1, 1, isRound, isFirst, isLastR, c == doneC, 0,
                     (c == doneC) && !m, (c == doneC) && m, rnd, m ? nr - rnd : rnd, nr);
         end
         if (c == abortAt) begin
            rst = 1'b0; start = 1'b0;
            tick();
            resetModel();
            checkIdle({tag, " after rst"}, 0);
            rst = 1'b1;
            return;
         end
         if (noise) begin
            start = 1'($urandom_range(1, 0));
            mode  = 1'($urandom_range(1, 0));
            Nk    = 4'($urandom_range(15, 0));
         end else begin
            start = 1'b0;
         end
         key_ready = kr[c];
         tick();
      end
      start = 1'b0;
      mEnc = !m; mDec = m; mMode = m; mRound = nr; mNr = nr;
      checkIdle($sformatf("m%0d nk%0d idle", m, nk), 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = 1'b0; Nk = 4'd0; key_ready = 1'b0;
      tick();
      tick();
      checkIdle("reset", 0);
      rst = 1'b1;
      tick();
      checkIdle("post reset idle", 0);

      runJob(0, 4'd4, 0, 0, 0);

      // Illegal Nk: one-cycle err, nothing else moves.
      start = 1'b1; Nk = 4'd5; mode = 1'b1;
      tick();
      start = 1'b0;
      checkIdle("illegal nk5 T+1", 1);
      tick();
      checkIdle("illegal nk5 T+2", 0);

      runJob(1, 4'd8, 0, 0, 0);
      runJob(0, 4'd6, 2, 0, 0);
      runJob(0, 4'd4, 0, 0, 1);
      runJob(0, 4'd4, 0, 9, 0);
      runJob(0, 4'd4, 0, 0, 0);

      for (int j = 0; j < 6; j++) begin
         logic [3:0] nkR;
         case ($urandom_range(2, 0))
            0:       nkR = 4'd4;
            1:       nkR = 4'd6;
            default: nkR = 4'd8;
         endcase
         runJob(1'($urandom_range(1, 0)), nkR, 1, 0, 1);
      end

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
